// File: rtl/core_avl_master_pkg.sv
// Shared types and constants for the core-to-Avalon-MM initiator bridge.
package core_avl_master_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam logic [1:0]  AVL_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AVL_RESP_SLVERR = 2'b10;
  localparam logic [1:0]  AVL_RESP_DECERR = 2'b11;
  localparam logic [31:0] FAULT_DATA_DEF  = 32'hDEADDEAD;

  function automatic logic is_fault(input logic [1:0] resp);
    return resp != AVL_RESP_OKAY;
  endfunction

endpackage

// File: rtl/core_avl_master_if.sv
// Core request/ready bus plus Avalon-MM initiator signals; master = bridge side.
interface core_avl_master_if;
  logic [29:0] core_addr;
  logic        core_start;
  logic        core_write;
  logic [31:0] core_data_wr;
  logic [3:0]  core_data_be;
  logic [31:0] core_data_rd;
  logic        core_ready;
  logic        core_fault;

  logic [31:0] avl_address;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic        avl_waitrequest;
  logic [31:0] avl_readdata;
  logic        avl_readdatavalid;
  logic [1:0]  avl_response;

  modport master (
    input  core_addr, core_start, core_write, core_data_wr, core_data_be,
    output core_data_rd, core_ready, core_fault,
    output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    input  avl_waitrequest, avl_readdata, avl_readdatavalid, avl_response
  );

  modport slave (
    output core_addr, core_start, core_write, core_data_wr, core_data_be,
    input  core_data_rd, core_ready, core_fault,
    input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    output avl_waitrequest, avl_readdata, avl_readdatavalid, avl_response
  );
endinterface

// File: rtl/core_avl_master_bus_watchdog.sv
// Saturating outstanding-cycle counter; expired flags the last allowed cycle.
module core_avl_master_bus_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int            CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr)                 r_cnt <= '0;
    else if (i_en && (r_cnt != LAST)) r_cnt <= r_cnt + 1'b1;
  end

  // TIMEOUT == 0 disables the watchdog entirely
  assign o_expired = (TIMEOUT > 0) && i_en && (r_cnt == LAST);
endmodule

// File: rtl/core_avl_master.sv
// One-at-a-time bridge from core request/ready bus to an Avalon-MM responder.
module core_avl_master
  import core_avl_master_pkg::*;
#(
  parameter int          TIMEOUT    = 1024,
  parameter logic [31:0] FAULT_DATA = FAULT_DATA_DEF
) (
  input logic                clk,
  input logic                rst,
  core_avl_master_if.master  bus
);
  state_e      r_state, w_state_nxt;
  logic        r_is_wr, w_is_wr_nxt;
  logic        r_avl_read, w_avl_read_nxt;
  logic        r_avl_write, w_avl_write_nxt;
  logic [31:0] r_avl_address, w_avl_address_nxt;
  logic [31:0] r_avl_writedata, w_avl_writedata_nxt;
  logic [3:0]  r_avl_byteenable, w_avl_byteenable_nxt;
  logic        r_core_ready, w_core_ready_nxt;
  logic        r_core_fault, w_core_fault_nxt;
  logic [31:0] r_core_data_rd, w_core_data_rd_nxt;
  logic        w_accept, w_done, w_abort, w_expired;

  core_avl_master_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == IDLE),
    .i_en      (r_state != IDLE),
    .o_expired (w_expired)
  );

  // Completion beats expiry; a read accepted without data is not completion.
  assign w_accept = (r_state == REQ) && !bus.avl_waitrequest;
  assign w_done   = (w_accept && (r_is_wr || bus.avl_readdatavalid)) ||
                    ((r_state == RESP) && bus.avl_readdatavalid);
  assign w_abort  = w_expired && !w_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.core_start) w_state_nxt = REQ;
      REQ:     if (w_done || w_abort) w_state_nxt = IDLE;
               else if (w_accept)     w_state_nxt = RESP;
      RESP:    if (w_done || w_abort) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_is_wr_nxt          = r_is_wr;
    w_avl_read_nxt       = r_avl_read;
    w_avl_write_nxt      = r_avl_write;
    w_avl_address_nxt    = r_avl_address;
    w_avl_writedata_nxt  = r_avl_writedata;
    w_avl_byteenable_nxt = r_avl_byteenable;
    w_core_ready_nxt     = 1'b0;
    w_core_fault_nxt     = 1'b0;
    w_core_data_rd_nxt   = r_core_data_rd;
    if ((r_state == IDLE) && bus.core_start) begin
      w_is_wr_nxt          = bus.core_write;
      w_avl_read_nxt       = !bus.core_write;
      w_avl_write_nxt      = bus.core_write;
      w_avl_address_nxt    = {bus.core_addr, 2'b00};
      w_avl_writedata_nxt  = bus.core_data_wr;
      w_avl_byteenable_nxt = bus.core_write ? bus.core_data_be : 4'hF;
    end
    if (w_accept || w_abort) begin
      w_avl_read_nxt  = 1'b0;
      w_avl_write_nxt = 1'b0;
    end
    if (w_done) begin
      w_core_ready_nxt = 1'b1;
      if (!r_is_wr) begin
        w_core_data_rd_nxt = bus.avl_readdata;
        w_core_fault_nxt   = is_fault(bus.avl_response);
      end
    end else if (w_abort) begin
      w_core_ready_nxt = 1'b1;
      w_core_fault_nxt = 1'b1;
      if (!r_is_wr) w_core_data_rd_nxt = FAULT_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_wr          <= 1'b0;
      r_avl_read       <= 1'b0;
      r_avl_write      <= 1'b0;
      r_avl_address    <= '0;
      r_avl_writedata  <= '0;
      r_avl_byteenable <= '0;
      r_core_ready     <= 1'b0;
      r_core_fault     <= 1'b0;
      r_core_data_rd   <= '0;
    end else begin
      r_is_wr          <= w_is_wr_nxt;
      r_avl_read       <= w_avl_read_nxt;
      r_avl_write      <= w_avl_write_nxt;
      r_avl_address    <= w_avl_address_nxt;
      r_avl_writedata  <= w_avl_writedata_nxt;
      r_avl_byteenable <= w_avl_byteenable_nxt;
      r_core_ready     <= w_core_ready_nxt;
      r_core_fault     <= w_core_fault_nxt;
      r_core_data_rd   <= w_core_data_rd_nxt;
    end
  end

  assign bus.avl_read       = r_avl_read;
  assign bus.avl_write      = r_avl_write;
  assign bus.avl_address    = r_avl_address;
  assign bus.avl_writedata  = r_avl_writedata;
  assign bus.avl_byteenable = r_avl_byteenable;
  assign bus.core_ready     = r_core_ready;
  assign bus.core_fault     = r_core_fault;
  assign bus.core_data_rd   = r_core_data_rd;
endmodule

// File: tb/tb_core_avl_master.sv
// Directed + randomized transactions against a cycle-count model of the bridge.
module tb_core_avl_master;
  import core_avl_master_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  core_avl_master_if bus();

  core_avl_master #(.TIMEOUT(TO), .FAULT_DATA(32'hDEADDEAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          npass = 0;
  int          ntot  = 0;
  logic [31:0] exp_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_idle();
    bus.core_start        = 1'b0;
    bus.core_write        = 1'b0;
    bus.core_addr         = '0;
    bus.core_data_wr      = '0;
    bus.core_data_be      = '0;
    bus.avl_waitrequest   = 1'b0;
    bus.avl_readdata      = '0;
    bus.avl_readdatavalid = 1'b0;
    bus.avl_response      = AVL_RESP_OKAY;
  endtask

  task automatic idle_cycles(input int n);
    drive_idle();
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".avl_read"},   32'(bus.avl_read), 32'd0);
    chk({tag, ".avl_write"},  32'(bus.avl_write), 32'd0);
    chk({tag, ".avl_addr"},   bus.avl_address, 32'd0);
    chk({tag, ".avl_wdata"},  bus.avl_writedata, 32'd0);
    chk({tag, ".avl_be"},     32'(bus.avl_byteenable), 32'd0);
    chk({tag, ".core_ready"}, 32'(bus.core_ready), 32'd0);
    chk({tag, ".core_fault"}, 32'(bus.core_fault), 32'd0);
    chk({tag, ".core_rd"},    bus.core_data_rd, 32'd0);
  endtask

  // Called at a falling edge; that cycle is the start cycle (cycle 0).
  // Responder accepts in cycle 1+nwait; read data comes lat cycles after accept.
  // Returns at the falling edge of the core_ready cycle, when the bridge is idle again.
  task automatic run_txn(input logic wr, input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] ben, input int nwait, input int lat,
                         input logic [1:0] resp, input logic [31:0] rdata,
                         input logic junk_rdv);
    int   c_acc, c_done, c_req_end, t_end;
    logic tmo, exp_fault;
    c_acc     = 1 + nwait;
    c_done    = wr ? c_acc : c_acc + lat;
    tmo       = c_done > TO;
    c_req_end = (c_acc < TO) ? c_acc : TO;
    t_end     = (tmo ? TO : c_done) + 1;
    exp_fault = tmo || (!wr && (resp != AVL_RESP_OKAY));

    bus.core_start        = 1'b1;
    bus.core_write        = wr;
    bus.core_addr         = a;
    bus.core_data_wr      = d;
    bus.core_data_be      = ben;
    bus.avl_waitrequest   = 1'b1;
    bus.avl_readdatavalid = junk_rdv;
    bus.avl_readdata      = $urandom;
    bus.avl_response      = 2'($urandom);

    for (int t = 1; t <= t_end; t++) begin
      @(negedge clk);
      // core side wiggles while busy; none of it may be picked up
      bus.core_start   = (t < t_end) ? 1'($urandom) : 1'b0;
      bus.core_write   = 1'($urandom);
      bus.core_addr    = 30'($urandom);
      bus.core_data_wr = $urandom;
      bus.core_data_be = 4'($urandom);

      chk("avl_read",  32'(bus.avl_read),  32'((t <= c_req_end) && !wr));
      chk("avl_write", 32'(bus.avl_write), 32'((t <= c_req_end) && wr));
      if (t <= c_req_end) begin
        chk("avl_address", bus.avl_address, {a, 2'b00});
        chk("avl_byteenable", 32'(bus.avl_byteenable), 32'(wr ? ben : 4'hF));
        if (wr) chk("avl_writedata", bus.avl_writedata, d);
      end
      chk("core_ready", 32'(bus.core_ready), 32'(t == t_end));
      if (t == t_end) begin
        if (!wr) exp_rd = tmo ? 32'hDEADDEAD : rdata;
        chk("core_fault", 32'(bus.core_fault), 32'(exp_fault));
      end else begin
        chk("core_fault_idle", 32'(bus.core_fault), 32'd0);
      end
      chk("core_data_rd", bus.core_data_rd, exp_rd);

      bus.avl_waitrequest = (t < c_acc);
      if (!wr && (t == c_done)) begin
        bus.avl_readdatavalid = 1'b1;
        bus.avl_readdata      = rdata;
        bus.avl_response      = resp;
      end else if (t < c_acc || t == t_end) begin
        bus.avl_readdatavalid = 1'($urandom);
        bus.avl_readdata      = $urandom;
        bus.avl_response      = 2'($urandom);
      end else begin
        bus.avl_readdatavalid = 1'b0;
      end
    end
    bus.core_start = 1'b0;
  endtask

  initial begin
    logic        r_wr;
    logic [1:0]  r_resp;
    int          r_nw, r_lat;

    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    idle_cycles(2);

    // zero-wait write
    run_txn(1'b1, 30'h0000_0100, 32'h1234_5678, 4'b0011, 0, 0, AVL_RESP_OKAY, '0, 1'b0);
    chk("wr_addr_const", bus.avl_address, 32'h0000_0400);
    idle_cycles(2);
    // stalled read, completion coinciding with the last watchdog cycle
    run_txn(1'b0, 30'h10, '0, 4'h0, 3, 4, AVL_RESP_OKAY, 32'hCAFEF00D, 1'b0);
    chk("rd_data_const", bus.core_data_rd, 32'hCAFEF00D);
    idle_cycles(1);
    run_txn(1'b0, 30'h22, '0, 4'h0, 1, 2, AVL_RESP_SLVERR, 32'h0BAD_BEEF, 1'b1);
    idle_cycles(1);
    run_txn(1'b0, 30'h33, '0, 4'h0, 0, 0, AVL_RESP_DECERR, 32'h5555_AAAA, 1'b0);
    idle_cycles(1);
    // waitrequest stuck: watchdog abort on read and on write
    run_txn(1'b0, 30'h44, '0, 4'h0, 100, 0, AVL_RESP_OKAY, 32'h1111_1111, 1'b1);
    chk("tmo_rd_const", bus.core_data_rd, 32'hDEADDEAD);
    idle_cycles(1);
    run_txn(1'b1, 30'h55, 32'hA5A5_A5A5, 4'hF, 100, 0, AVL_RESP_OKAY, '0, 1'b0);
    // read accepted on the expiry cycle but no data: aborted
    run_txn(1'b0, 30'h66, '0, 4'h0, 7, 2, AVL_RESP_OKAY, 32'h2222_2222, 1'b0);
    idle_cycles(1);

    // back-to-back with start held high and zero-wait responder
    for (int i = 0; i < 6; i++)
      run_txn(1'(i % 2), 30'(i * 3 + 1), $urandom, 4'($urandom), 0, 0,
              AVL_RESP_OKAY, $urandom, 1'b1);
    idle_cycles(2);

    // reset while waiting in RESP
    bus.core_start = 1'b1; bus.core_write = 1'b0; bus.core_addr = 30'h77;
    @(negedge clk);
    bus.core_start = 1'b0; bus.avl_waitrequest = 1'b0;
    @(negedge clk);
    bus.avl_waitrequest = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_resp");
    rst = 1'b0;
    exp_rd = '0;
    @(negedge clk);
    chk("rst_no_ready", 32'(bus.core_ready), 32'd0);
    run_txn(1'b0, 30'h78, '0, 4'h0, 1, 1, AVL_RESP_OKAY, 32'h7E57_0001, 1'b0);
    idle_cycles(1);

    for (int i = 0; i < 40; i++) begin
      r_wr   = 1'($urandom);
      r_nw   = ($urandom_range(7, 0) == 0) ? 9 : int'($urandom_range(3, 0));
      r_lat  = int'($urandom_range(4, 0));
      r_resp = ($urandom_range(3, 0) == 0) ? 2'($urandom) : AVL_RESP_OKAY;
      run_txn(r_wr, 30'($urandom), $urandom, 4'($urandom), r_nw, r_lat, r_resp,
              $urandom, 1'($urandom));
      if ($urandom_range(2, 0) != 0) idle_cycles(int'($urandom_range(2, 1)));
    end

    idle_cycles(2);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
